// File: rtl/iob_axil2iob_pkg.sv
// rtl/iob_axil2iob_pkg.sv - shared FSM encodings and AXI response codes for the AXI-Lite to IOb bridge
package iob_axil2iob_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RD_RESP = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // last_grant encoding: 1 means the write side won the previous tie
  localparam logic GRANT_RD = 1'b0;
  localparam logic GRANT_WR = 1'b1;

endpackage

// File: rtl/iob_reg_re.sv
// rtl/iob_reg_re.sv - register with load enable, clock enable and asynchronous active-low reset
module iob_reg_re #(
  parameter int                DATA_W  = 1,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_n_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      data_o <= RST_VAL;
    end else if (cke_i && en_i) begin
      data_o <= data_i;
    end
  end

endmodule

// File: rtl/iob_axil2iob.sv
// rtl/iob_axil2iob.sv - AXI-Lite subordinate to IOb manager bridge, one transaction in flight
module iob_axil2iob
  import iob_axil2iob_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_n_i,
  input  logic                axil_awvalid_i,
  output logic                axil_awready_o,
  input  logic [ADDR_W-1:0]   axil_awaddr_i,
  input  logic                axil_wvalid_i,
  output logic                axil_wready_o,
  input  logic [DATA_W-1:0]   axil_wdata_i,
  input  logic [DATA_W/8-1:0] axil_wstrb_i,
  output logic                axil_bvalid_o,
  input  logic                axil_bready_i,
  output logic [1:0]          axil_bresp_o,
  input  logic                axil_arvalid_i,
  output logic                axil_arready_o,
  input  logic [ADDR_W-1:0]   axil_araddr_i,
  output logic                axil_rvalid_o,
  input  logic                axil_rready_i,
  output logic [DATA_W-1:0]   axil_rdata_o,
  output logic [1:0]          axil_rresp_o,
  output logic                iob_valid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i,
  output logic                iob_rready_o
);

  localparam int STRB_W = DATA_W / 8;

  state_t              state, state_nxt;
  logic                aw_full, w_full, ar_full, last_grant;
  logic [ADDR_W-1:0]   aw_addr, ar_addr;
  logic [DATA_W-1:0]   w_data, rdata;
  logic [STRB_W-1:0]   w_strb, strb_eff;
  logic                aw_hs, w_hs, ar_hs;
  logic                wr_avail, rd_avail, pick_wr;
  logic                wr_consume, rd_consume, grant_en, rdata_en;

  assign aw_hs = axil_awvalid_i & ~aw_full;
  assign w_hs  = axil_wvalid_i & ~w_full;
  assign ar_hs = axil_arvalid_i & ~ar_full;

  // IDLE looks at beats arriving this cycle too, so a request reaches IOb one cycle after its handshake
  assign wr_avail = (aw_full | aw_hs) & (w_full | w_hs);
  assign rd_avail = ar_full | ar_hs;
  assign pick_wr  = wr_avail & (~rd_avail | (last_grant == GRANT_RD));
  assign strb_eff = w_full ? w_strb : axil_wstrb_i;

  assign axil_awready_o = ~aw_full;
  assign axil_wready_o  = ~w_full;
  assign axil_arready_o = ~ar_full;
  assign axil_bresp_o   = RESP_OKAY;
  assign axil_rresp_o   = RESP_OKAY;
  assign axil_rdata_o   = rdata;

  iob_reg_re #(.DATA_W(1), .RST_VAL(1'b0)) aw_full_reg (.clk_i, .cke_i, .arst_n_i, .en_i(1'b1),
    .data_i((aw_full | aw_hs) & ~wr_consume), .data_o(aw_full));
  iob_reg_re #(.DATA_W(1), .RST_VAL(1'b0)) w_full_reg (.clk_i, .cke_i, .arst_n_i, .en_i(1'b1),
    .data_i((w_full | w_hs) & ~wr_consume), .data_o(w_full));
  iob_reg_re #(.DATA_W(1), .RST_VAL(1'b0)) ar_full_reg (.clk_i, .cke_i, .arst_n_i, .en_i(1'b1),
    .data_i((ar_full | ar_hs) & ~rd_consume), .data_o(ar_full));
  iob_reg_re #(.DATA_W(ADDR_W)) aw_addr_reg (.clk_i, .cke_i, .arst_n_i, .en_i(aw_hs),
    .data_i(axil_awaddr_i), .data_o(aw_addr));
  iob_reg_re #(.DATA_W(DATA_W)) w_data_reg (.clk_i, .cke_i, .arst_n_i, .en_i(w_hs),
    .data_i(axil_wdata_i), .data_o(w_data));
  iob_reg_re #(.DATA_W(STRB_W)) w_strb_reg (.clk_i, .cke_i, .arst_n_i, .en_i(w_hs),
    .data_i(axil_wstrb_i), .data_o(w_strb));
  iob_reg_re #(.DATA_W(ADDR_W)) ar_addr_reg (.clk_i, .cke_i, .arst_n_i, .en_i(ar_hs),
    .data_i(axil_araddr_i), .data_o(ar_addr));
  iob_reg_re #(.DATA_W(DATA_W)) rdata_reg (.clk_i, .cke_i, .arst_n_i, .en_i(rdata_en),
    .data_i(iob_rdata_i), .data_o(rdata));
  iob_reg_re #(.DATA_W(1), .RST_VAL(GRANT_RD)) last_grant_reg (.clk_i, .cke_i, .arst_n_i,
    .en_i(grant_en), .data_i(pick_wr), .data_o(last_grant));

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state <= ST_IDLE;
    end else if (cke_i) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    wr_consume    = 1'b0;
    rd_consume    = 1'b0;
    grant_en      = 1'b0;
    rdata_en      = 1'b0;
    iob_valid_o   = 1'b0;
    iob_rready_o  = 1'b0;
    iob_addr_o    = aw_addr;
    iob_wdata_o   = w_data;
    iob_wstrb_o   = w_strb;
    axil_bvalid_o = 1'b0;
    axil_rvalid_o = 1'b0;
    case (state)
      ST_IDLE: begin
        // only a genuine tie moves the round-robin pointer
        grant_en = wr_avail & rd_avail;
        if (pick_wr) begin
          // an all-zero strobe would look like a read on IOb, so answer it locally
          if (strb_eff == '0) begin
            wr_consume = 1'b1;
            state_nxt  = ST_WR_RESP;
          end else begin
            state_nxt  = ST_WR_REQ;
          end
        end else if (rd_avail) begin
          state_nxt = ST_RD_REQ;
        end
      end
      ST_WR_REQ: begin
        iob_valid_o = 1'b1;
        if (iob_ready_i) begin
          wr_consume = 1'b1;
          state_nxt  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        axil_bvalid_o = 1'b1;
        if (axil_bready_i) state_nxt = ST_IDLE;
      end
      ST_RD_REQ: begin
        iob_valid_o = 1'b1;
        iob_addr_o  = ar_addr;
        iob_wstrb_o = '0;
        if (iob_ready_i) begin
          rd_consume = 1'b1;
          state_nxt  = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        iob_rready_o = 1'b1;
        if (iob_rvalid_i) begin
          rdata_en  = 1'b1;
          state_nxt = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        axil_rvalid_o = 1'b1;
        if (axil_rready_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_iob_axil2iob.sv
// tb/tb_iob_axil2iob.sv - self-checking bench for the AXI-Lite to IOb bridge
module tb_iob_axil2iob;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } req_t;

  logic        clk = 1'b0;
  logic        cke = 1'b1;
  logic        arst_n = 1'b0;
  logic        awvalid = 1'b0, awready;
  logic [31:0] awaddr = '0;
  logic        wvalid = 1'b0, wready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        bvalid, bready = 1'b1;
  logic [1:0]  bresp, rresp;
  logic        arvalid = 1'b0, arready;
  logic [31:0] araddr = '0;
  logic        rvalid, rready = 1'b1;
  logic [31:0] rdata;
  logic        iob_valid, iob_rready;
  logic [31:0] iob_addr, iob_wdata;
  logic [3:0]  iob_wstrb;
  logic        iob_ready = 1'b1;
  logic        iob_rvalid = 1'b0;
  logic [31:0] iob_rdata = '0;

  int          n_cmp = 0;
  int          n_bad = 0;
  req_t        req_q[$];
  logic [31:0] exp_r[$];
  int          exp_b = 0;
  logic [31:0] rd_seed = 32'h1000_0000;

  always #5 clk = ~clk;

  iob_axil2iob #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .cke_i(cke), .arst_n_i(arst_n),
    .axil_awvalid_i(awvalid), .axil_awready_o(awready), .axil_awaddr_i(awaddr),
    .axil_wvalid_i(wvalid), .axil_wready_o(wready), .axil_wdata_i(wdata), .axil_wstrb_i(wstrb),
    .axil_bvalid_o(bvalid), .axil_bready_i(bready), .axil_bresp_o(bresp),
    .axil_arvalid_i(arvalid), .axil_arready_o(arready), .axil_araddr_i(araddr),
    .axil_rvalid_o(rvalid), .axil_rready_i(rready), .axil_rdata_o(rdata), .axil_rresp_o(rresp),
    .iob_valid_o(iob_valid), .iob_addr_o(iob_addr), .iob_wdata_o(iob_wdata), .iob_wstrb_o(iob_wstrb),
    .iob_ready_i(iob_ready), .iob_rvalid_i(iob_rvalid), .iob_rdata_i(iob_rdata),
    .iob_rready_o(iob_rready)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event expected none", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every IOb request, B beat and R beat must match the model queues, in order
  always @(negedge clk) begin
    if (arst_n) begin
      if (iob_valid) begin
        if (req_q.size() == 0) unexpected("iob_valid_extra");
        else begin
          chk("iob_addr", iob_addr, req_q[0].addr);
          chk("iob_wstrb", iob_wstrb, req_q[0].strb);
          if (req_q[0].strb != 0) chk("iob_wdata", iob_wdata, req_q[0].data);
          if (iob_ready) void'(req_q.pop_front());
        end
      end
      if (bvalid) begin
        if (exp_b == 0) unexpected("b_beat_extra");
        else begin
          chk("bresp", bresp, 2'b00);
          if (bready) exp_b--;
        end
      end
      if (rvalid) begin
        if (exp_r.size() == 0) unexpected("r_beat_extra");
        else begin
          chk("rdata", rdata, exp_r[0]);
          chk("rresp", rresp, 2'b00);
          if (rready) void'(exp_r.pop_front());
        end
      end
    end
  end

  // Acts as the IOb peripheral until every expected transfer has completed
  task automatic service(input int max_cycles);
    bit done = 0;
    iob_ready = 1'b1;
    for (int c = 0; c < max_cycles; c++) begin
      if (req_q.size() == 0 && exp_b == 0 && exp_r.size() == 0 && !rvalid && !bvalid && !iob_rready) begin
        done = 1;
        break;
      end
      iob_rvalid = iob_rready;
      if (iob_rready) begin
        iob_rdata = rd_seed;
        exp_r.push_back(rd_seed);
        rd_seed = rd_seed + 32'h11;
      end
      tick();
    end
    iob_rvalid = 1'b0;
    if (!done) unexpected("service_timeout");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, awready, 1);
    chk({tag, "_wready"}, wready, 1);
    chk({tag, "_arready"}, arready, 1);
    chk({tag, "_bvalid"}, bvalid, 0);
    chk({tag, "_rvalid"}, rvalid, 0);
    chk({tag, "_iob_valid"}, iob_valid, 0);
    chk({tag, "_iob_rready"}, iob_rready, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_bresp"}, bresp, 0);
    chk({tag, "_rresp"}, rresp, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk);
    #1 arst_n = 1'b1;
    tick();

    // Back-to-back AW+W, immediate IOb ready
    req_q.push_back('{32'h10, 32'hDEADBEEF, 4'hF});
    exp_b++;
    awvalid = 1; awaddr = 32'h10; wvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    tick();
    awvalid = 0; wvalid = 0;
    chk("t1_iob_valid_c1", iob_valid, 1);
    chk("t1_iob_addr_c1", iob_addr, 32'h10);
    chk("t1_iob_wdata_c1", iob_wdata, 32'hDEADBEEF);
    chk("t1_awready_c1", awready, 0);
    tick();
    chk("t1_bvalid_c2", bvalid, 1);
    chk("t1_iob_valid_c2", iob_valid, 0);
    tick();
    chk("t1_bvalid_c3", bvalid, 0);

    // W two cycles ahead of AW, IOb ready held off for three cycles
    iob_ready = 0;
    req_q.push_back('{32'h44, 32'hCAFEF00D, 4'h3});
    exp_b++;
    wvalid = 1; wdata = 32'hCAFEF00D; wstrb = 4'h3;
    tick();
    wvalid = 0;
    chk("t2_wready_full", wready, 0);
    chk("t2_iob_valid_no_aw", iob_valid, 0);
    tick();
    tick();
    awvalid = 1; awaddr = 32'h44;
    tick();
    awvalid = 0;
    for (int k = 0; k < 3; k++) begin
      chk("t2_iob_valid_held", iob_valid, 1);
      tick();
    end
    iob_ready = 1;
    chk("t2_iob_valid_c4", iob_valid, 1);
    tick();
    iob_ready = 0;
    chk("t2_iob_valid_drop", iob_valid, 0);
    chk("t2_bvalid", bvalid, 1);
    tick();
    chk("t2_bvalid_done", bvalid, 0);

    // Read with delayed IOb data and a stalled R channel
    iob_ready = 1; rready = 0;
    req_q.push_back('{32'h20, 32'h0, 4'h0});
    arvalid = 1; araddr = 32'h20;
    tick();
    arvalid = 0;
    chk("t3_iob_valid_c1", iob_valid, 1);
    chk("t3_iob_wstrb_c1", iob_wstrb, 0);
    tick();
    chk("t3_iob_rready_c2", iob_rready, 1);
    chk("t3_iob_valid_c2", iob_valid, 0);
    tick();
    iob_rvalid = 1; iob_rdata = 32'h12345678;
    exp_r.push_back(32'h12345678);
    chk("t3_rvalid_c3", rvalid, 0);
    tick();
    iob_rvalid = 0; iob_rdata = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      chk("t3_rvalid_held", rvalid, 1);
      chk("t3_rdata_stable", rdata, 32'h12345678);
      tick();
    end
    rready = 1;
    tick();
    chk("t3_rvalid_done", rvalid, 0);

    // Simultaneous write and read twice: write,read then read,write
    req_q.push_back('{32'h100, 32'hA5A5A5A5, 4'hF});
    req_q.push_back('{32'h104, 32'h0, 4'h0});
    exp_b++;
    awvalid = 1; awaddr = 32'h100; wvalid = 1; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
    arvalid = 1; araddr = 32'h104;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("t4_first_is_write", iob_wstrb, 4'hF);
    service(40);
    req_q.push_back('{32'h20C, 32'h0, 4'h0});
    req_q.push_back('{32'h208, 32'h5A5A0000, 4'hC});
    exp_b++;
    awvalid = 1; awaddr = 32'h208; wvalid = 1; wdata = 32'h5A5A0000; wstrb = 4'hC;
    arvalid = 1; araddr = 32'h20C;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("t4_second_is_read", iob_addr, 32'h20C);
    service(40);

    // Zero-strobe write is answered without touching IOb
    iob_ready = 0;
    exp_b++;
    awvalid = 1; awaddr = 32'h50; wvalid = 1; wdata = 32'h11111111; wstrb = 4'h0;
    tick();
    awvalid = 0; wvalid = 0;
    chk("t5_iob_valid", iob_valid, 0);
    chk("t5_bvalid", bvalid, 1);
    tick();
    chk("t5_bvalid_done", bvalid, 0);
    chk("t5_awready", awready, 1);

    // Reset while waiting for read data drops the transaction
    iob_ready = 1;
    req_q.push_back('{32'h30, 32'h0, 4'h0});
    arvalid = 1; araddr = 32'h30;
    tick();
    arvalid = 0;
    tick();
    chk("t6_iob_rready_pre", iob_rready, 1);
    arst_n = 0;
    @(negedge clk);
    chk_reset_outputs("t6");
    @(posedge clk);
    #1 arst_n = 1;
    iob_rvalid = 1; iob_rdata = 32'hBAD0BAD0;
    tick();
    tick();
    iob_rvalid = 0;
    for (int k = 0; k < 3; k++) begin
      chk("t6_rvalid_none", rvalid, 0);
      chk("t6_iob_rready_none", iob_rready, 0);
      tick();
    end

    chk("end_req_q_empty", req_q.size(), 0);
    chk("end_b_outstanding", exp_b, 0);
    chk("end_r_q_empty", exp_r.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
